window_line_buffer: RTL and testbench
=====================================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter MAX_W, default 1024, maximum line width and line-RAM depth.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the size and coordinate fields.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-008 frame_w, frame_h  input  CNT_W each  frame size; latched when start is accepted.
REQ-009 border_mode  input  1  0 = zero pad, 1 = replicate edge; latched with start.
REQ-010 in_data / in_valid / in_ready  input / input / output  DATA_W / 1 / 1  raster-order pixel stream.
REQ-011 out_win / out_valid / out_ready  output / output / input  9*DATA_W / 1 / 1  3x3 window stream; tap k = row*3+col occupies bits [k*DATA_W +: DATA_W], with tap 4 as the centre.
REQ-012 out_row, out_col  output  CNT_W each  centre coordinate of out_win.
REQ-013 busy, frame_done, cfg_err  output  1 each  frame in progress; one-cycle pulse after the last window; one-cycle pulse on a rejected start.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-015 IDLE -> RUN on start when 2<=frame_w<=MAX_W and 2<=frame_h; an out-of-range start SHALL pulse cfg_err and leave the FSM in IDLE.
REQ-016 start in any state other than IDLE SHALL be ignored.
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both high; in_ready SHALL be high only in RUN, and only when the output register is empty or being read that same cycle.
REQ-018 out_valid, once asserted, SHALL hold out_win, out_row and out_col stable until the output transfer.
REQ-019 Accepted-pixel count p SHALL increment per input transfer; RUN -> FLUSH when p reaches frame_w*frame_h.
REQ-020 The window with raster index k SHALL load into the output register on the clock edge that accepts input pixel k+frame_w+1, giving one-row-plus-one-pixel latency.
REQ-021 In FLUSH, the remaining frame_w+1 windows SHALL be generated without input, at one per cycle while out_ready is high.
REQ-022 FLUSH -> DONE after the last output transfer; DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-023 Taps outside the frame SHALL be 0 when border_mode=0, and the nearest in-frame pixel when border_mode=1, with rows and columns clamped independently.
REQ-024 Column context SHALL NOT leak across row boundaries: the column 0 left taps and the column W-1 right taps follow REQ-023.
REQ-025 Two line RAMs SHALL hold the previous two rows, addressed by a column counter that wraps from frame_w-1 to 0.
REQ-026 Size products and comparisons SHALL be computed at 2*CNT_W bits, with no truncation.
REQ-027 With out_ready low, the block SHALL stall with no loss or duplication of windows.
REQ-028 busy SHALL be high in RUN, FLUSH and DONE.

Reset
REQ-029 Reset SHALL force IDLE, with in_ready=0, out_valid=0, busy=0, frame_done=0, cfg_err=0, out_win=0, out_row=0, out_col=0, and all counters at 0.
REQ-030 Line-RAM contents SHALL NOT be reset; no stale data SHALL reach out_win, because the border masking of REQ-023 covers it.
REQ-031 A reset mid-frame SHALL abort the frame, emit no frame_done, and leave the block ready to accept start on the first cycle after release.

Structure
REQ-032 A shared package window_pkg SHALL hold the state enum, the border_mode encodings (BORDER_ZERO=0, BORDER_REPL=1) and the tap index constants.
REQ-033 The sub-module line_ram SHALL be a simple dual-port MAX_W x DATA_W memory with synchronous read, instantiated twice.

Verification
REQ-034 4x3 frame with pixels 0..11, border_mode=0, out_ready=1 -> 12 windows; centre (0,0) taps = {0,0,0, 0,0,1, 0,4,5}; frame_done after window 11.
REQ-035 Same frame with border_mode=1 -> centre (2,3) taps = {6,7,7, 10,11,11, 10,11,11}.
REQ-036 out_ready toggled randomly at 50% and in_valid gapped, on an 8x8 frame -> output equals the no-stall run exactly, with 64 windows.
REQ-037 start with frame_w=1, then with frame_w=MAX_W+1 -> cfg_err pulses twice, busy stays 0 and in_ready stays 0.
REQ-038 reset asserted after 20 pixels of a 16x16 frame -> all outputs at reset values; a new 4x3 frame then passes REQ-034.
REQ-039 start pulsed during RUN -> ignored; frame completes with the original size.

Source files
------------

// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window line buffer.
//   state_t      : controller states
//   BORDER_*     : border_mode encodings
//   TAP_*        : tap positions inside out_win (tap = row*3 + col)
package window_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic BORDER_ZERO = 1'b0;
   localparam logic BORDER_REPL = 1'b1;

   localparam int NUM_TAPS = 9;
   localparam int TAP_TL = 0;
   localparam int TAP_TC = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_C  = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_BC = 7;
   localparam int TAP_BR = 8;

   function automatic int tap_idx(input int row, input int col);
      return row * 3 + col;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory, one write port and one synchronous read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every rising edge
//   rd_data : registered read data
// Contents are deliberately not reset.
module line_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/window_line_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream, with zero or
// replicate border handling.
//   clk, reset               : clock, async active-high reset
//   start, frame_w, frame_h  : frame request and size (latched in IDLE)
//   border_mode              : 0 zero pad, 1 replicate edge
//   in_data/in_valid/in_ready: pixel stream in
//   out_win/out_valid/out_ready, out_row/out_col : window stream out
//   busy, frame_done, cfg_err: status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bad sizes pulse cfg_err
// ST_RUN   | accepting pixels, windows lag by one row plus one pixel
// ST_FLUSH | emitting the last frame_w+1 windows from a virtual row
// ST_DONE  | one-cycle frame_done, back to idle
module window_line_buffer
   import window_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int MAX_W  = 1024,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      frame_w,
   input  logic [CNT_W-1:0]      frame_h,
   input  logic                  border_mode,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [9*DATA_W-1:0]   out_win,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      out_row,
   output logic [CNT_W-1:0]      out_col,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  cfg_err
);

   localparam int ADDR_W = $clog2(MAX_W);
   localparam int P_W    = 2 * CNT_W;
   localparam int RW     = CNT_W + 1;

   state_t state, state_nxt;

   logic [CNT_W-1:0] w_lat, h_lat;
   logic             border_lat;
   logic [P_W-1:0]   total, p_cnt;
   logic [CNT_W-1:0] col, col_next, ctr_col;
   logic [RW-1:0]    row, ctr_row, h_last, flush_cnt;
   logic [2:0][DATA_W-1:0] s_new, s_old, new_col;
   logic [2:0][2:0][DATA_W-1:0] raw, hcl, tap;
   logic [9*DATA_W-1:0] win_nxt;
   logic [DATA_W-1:0] ram1_rd, ram2_rd, pix;
   logic [ADDR_W-1:0] rd_addr;
   logic [P_W-1:0]   fw_ext, fh_ext;
   logic cfg_ok, start_ok, start_bad, step, emit, out_free, last_pix, col_last, repl;

   assign fw_ext   = P_W'(frame_w);
   assign fh_ext   = P_W'(frame_h);
   assign cfg_ok   = (fw_ext >= P_W'(2)) && (fw_ext <= P_W'(MAX_W)) && (fh_ext >= P_W'(2));
   assign out_free = !out_valid || out_ready;
   assign last_pix = (p_cnt + P_W'(1)) == total;
   assign col_last = (col == w_lat - CNT_W'(1));
   assign col_next = col_last ? '0 : col + CNT_W'(1);
   assign repl     = (border_lat == BORDER_REPL);
   assign h_last   = {1'b0, h_lat} - RW'(1);

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state and control outputs
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      step       = 1'b0;
      start_ok   = 1'b0;
      start_bad  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (cfg_ok) begin
                  start_ok  = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         ST_RUN: begin
            in_ready = out_free;
            step     = in_valid && out_free;
            if (step && last_pix) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            step = out_free && (flush_cnt != '0);
            if (flush_cnt == '0 && out_free) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Flush steps push a virtual zero pixel through the same path as real ones.
   assign pix = (state == ST_RUN) ? in_data : '0;

   // Read the column the next step will consume, so data is ready on that edge.
   assign rd_addr = step ? col_next[ADDR_W-1:0] : col[ADDR_W-1:0];

   line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_W), .ADDR_W(ADDR_W)) u_ram_prev1 (
      .clk(clk), .wr_en(step), .wr_addr(col[ADDR_W-1:0]), .wr_data(pix),
      .rd_addr(rd_addr), .rd_data(ram1_rd));

   line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_W), .ADDR_W(ADDR_W)) u_ram_prev2 (
      .clk(clk), .wr_en(step), .wr_addr(col[ADDR_W-1:0]), .wr_data(ram1_rd),
      .rd_addr(rd_addr), .rd_data(ram2_rd));

   assign new_col[0] = ram2_rd;
   assign new_col[1] = ram1_rd;
   assign new_col[2] = pix;

   // A step at column 0 completes the previous row's last window (its right
   // column is off-frame); otherwise the window sits one row up, one column left.
   always_comb begin
      if (col == '0) begin
         ctr_row = row - RW'(2);
         ctr_col = w_lat - CNT_W'(1);
      end else begin
         ctr_row = row - RW'(1);
         ctr_col = col - CNT_W'(1);
      end
      emit = (row >= RW'(2)) || (row == RW'(1) && col != '0);
   end

   // Columns clamp first, then rows, so corners replicate the centre-most pixel.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         raw[r][0] = s_old[r];
         raw[r][1] = s_new[r];
         raw[r][2] = new_col[r];
      end
      hcl = raw;
      for (int r = 0; r < 3; r++) begin
         if (ctr_col == '0)                  hcl[r][0] = repl ? raw[r][1] : '0;
         if (ctr_col == w_lat - CNT_W'(1))   hcl[r][2] = repl ? raw[r][1] : '0;
      end
      tap = hcl;
      for (int c = 0; c < 3; c++) begin
         if (ctr_row == '0)    tap[0][c] = repl ? hcl[1][c] : '0;
         if (ctr_row == h_last) tap[2][c] = repl ? hcl[1][c] : '0;
      end
      win_nxt = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            win_nxt[tap_idx(r, c)*DATA_W +: DATA_W] = tap[r][c];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_lat      <= '0;
         h_lat      <= '0;
         border_lat <= BORDER_ZERO;
         total      <= '0;
         p_cnt      <= '0;
         col        <= '0;
         row        <= '0;
         flush_cnt  <= '0;
         s_new      <= '0;
         s_old      <= '0;
         out_win    <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_valid  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= start_bad;
         if (start_ok) begin
            w_lat      <= frame_w;
            h_lat      <= frame_h;
            border_lat <= border_mode;
            total      <= fw_ext * fh_ext;
            p_cnt      <= '0;
            col        <= '0;
            row        <= '0;
         end
         if (state == ST_RUN && step) p_cnt <= p_cnt + P_W'(1);
         if (state == ST_RUN && step && last_pix)
            flush_cnt <= {1'b0, w_lat} + RW'(1);
         else if (state == ST_FLUSH && step)
            flush_cnt <= flush_cnt - RW'(1);
         if (step) begin
            col   <= col_next;
            if (col_last) row <= row + RW'(1);
            s_old <= s_new;
            s_new <= new_col;
         end
         if (step && emit) begin
            out_win   <= win_nxt;
            out_row   <= ctr_row[CNT_W-1:0];
            out_col   <= ctr_col;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;
   localparam int DATA_W = 8;
   localparam int MAX_W  = 1024;
   localparam int CNT_W  = 16;
   localparam int WIN_W  = 9 * DATA_W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic border_mode = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [CNT_W-1:0] frame_w = '0;
   logic [CNT_W-1:0] frame_h = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic in_ready, out_valid, busy, frame_done, cfg_err;
   logic [WIN_W-1:0] out_win;
   logic [CNT_W-1:0] out_row, out_col;

   window_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_w(frame_w), .frame_h(frame_h),
      .border_mode(border_mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_win(out_win), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done),
      .cfg_err(cfg_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [WIN_W-1:0] win;
      logic [CNT_W-1:0] row;
      logic [CNT_W-1:0] col;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int pix_mem [0:255];
   logic [WIN_W-1:0] cap_win [0:255];
   logic [WIN_W-1:0] ref_win [0:255];
   int checks = 0, errors = 0;
   int got_cnt = 0, cur_w = 1, done_cnt = 0, cfg_cnt = 0, idx;
   bit chk_en = 0, rdy_rand = 0;

   task automatic check(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Window from the frame definition: out-of-frame taps are 0 or the
   // nearest in-frame pixel, rows and columns clamped independently.
   function automatic logic [WIN_W-1:0] model_win(input int w, input int h, input bit m,
                                                   input int r, input int c);
      logic [WIN_W-1:0] res;
      int rr, cc, v;
      bit outside;
      res = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            outside = (rr < 0) || (rr >= h) || (cc < 0) || (cc >= w);
            if (outside && !m) v = 0;
            else begin
               if (rr < 0) rr = 0;
               if (rr >= h) rr = h - 1;
               if (cc < 0) cc = 0;
               if (cc >= w) cc = w - 1;
               v = pix_mem[rr*w + cc];
            end
            res[((dr+1)*3 + (dc+1))*DATA_W +: DATA_W] = v[DATA_W-1:0];
         end
      end
      return res;
   endfunction

   function automatic logic [WIN_W-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      logic [WIN_W-1:0] res;
      res = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
      return res;
   endfunction

   // Scoreboard: every output transfer is compared against the model queue.
   always @(negedge clk) begin
      if (!reset && chk_en && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got window row %0d col %0d, expected none", out_row, out_col);
         end else begin
            e = exp_q.pop_front();
            if (out_win !== e.win || out_row !== e.row || out_col !== e.col) begin
               errors++;
               $display("FAIL sb_window: got r%0d c%0d %h expected r%0d c%0d %h",
                        out_row, out_col, out_win, e.row, e.col, e.win);
            end
         end
         idx = int'(out_row) * cur_w + int'(out_col);
         if (idx >= 0 && idx < 256) cap_win[idx] = out_win;
         got_cnt++;
      end
      if (frame_done) done_cnt++;
      if (cfg_err) cfg_cnt++;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int w, input int h, input bit m);
      frame_w = CNT_W'(w);
      frame_h = CNT_W'(h);
      border_mode = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_pixel(input int d);
      bit ok;
      in_data = DATA_W'(d);
      in_valid = 1'b1;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL in_accept: pixel %0d not accepted within 200 cycles", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input bit m, input bit stall,
                            input bit kind, input bit inject);
      bit ok;
      exp_t x;
      for (int i = 0; i < w*h; i++) pix_mem[i] = kind ? (i*37 + 5) % 256 : i;
      exp_q.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            x.win = model_win(w, h, m, r, c);
            x.row = CNT_W'(r);
            x.col = CNT_W'(c);
            exp_q.push_back(x);
         end
      got_cnt = 0;
      cur_w = w;
      chk_en = 1;
      rdy_rand = stall;
      pulse_start(w, h, m);
      check("busy_after_start", WIN_W'(busy), WIN_W'(1));
      for (int i = 0; i < w*h; i++) begin
         send_pixel(pix_mem[i]);
         if (inject && i == 3) begin
            pulse_start(2, 2, 1);
            check("cfg_err_in_run", WIN_W'(cfg_err), WIN_W'(0));
            frame_w = CNT_W'(w);
            frame_h = CNT_W'(h);
         end
         if (stall) repeat ($urandom_range(0, 2)) tick();
      end
      ok = 0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1;
            break;
         end
      end
      check("frame_done_seen", WIN_W'(ok), WIN_W'(1));
      check("window_count", WIN_W'(got_cnt), WIN_W'(w*h));
      check("queue_empty", WIN_W'(exp_q.size()), WIN_W'(0));
      rdy_rand = 0;
      tick();
      check("busy_after_done", WIN_W'(busy), WIN_W'(0));
      check("frame_done_pulse", WIN_W'(frame_done), WIN_W'(0));
      chk_en = 0;
   endtask

   int d0, c0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      tick();
      tick();
      check("rst_out_valid", WIN_W'(out_valid), WIN_W'(0));
      check("rst_in_ready", WIN_W'(in_ready), WIN_W'(0));
      check("rst_busy", WIN_W'(busy), WIN_W'(0));
      check("rst_cfg_err", WIN_W'(cfg_err), WIN_W'(0));
      check("rst_out_win", out_win, WIN_W'(0));
      check("rst_out_row_col", WIN_W'({out_row, out_col}), WIN_W'(0));
      reset = 1'b0;
      tick();

      // 4x3 zero pad
      run_frame(4, 3, 0, 0, 0, 0);
      check("z_centre_0_0", cap_win[0], pack9(0, 0, 0, 0, 0, 1, 0, 4, 5));
      check("z_centre_2_3", cap_win[11], pack9(6, 7, 0, 10, 11, 0, 0, 0, 0));

      // 4x3 replicate
      run_frame(4, 3, 1, 0, 0, 0);
      check("r_centre_2_3", cap_win[11], pack9(6, 7, 7, 10, 11, 11, 10, 11, 11));
      check("r_centre_0_0", cap_win[0], pack9(0, 0, 1, 0, 0, 1, 4, 4, 5));

      // 8x8 without then with back-pressure and input gaps
      run_frame(8, 8, 1, 0, 1, 0);
      for (int i = 0; i < 64; i++) ref_win[i] = cap_win[i];
      for (int i = 0; i < 64; i++) cap_win[i] = '0;
      run_frame(8, 8, 1, 1, 1, 0);
      for (int i = 0; i < 64; i++) check($sformatf("stall_eq_%0d", i), cap_win[i], ref_win[i]);

      // rejected sizes
      c0 = cfg_cnt;
      pulse_start(1, 4, 0);
      check("cfg_err_w1", WIN_W'(cfg_err), WIN_W'(1));
      check("cfg_busy_w1", WIN_W'(busy), WIN_W'(0));
      check("cfg_ready_w1", WIN_W'(in_ready), WIN_W'(0));
      tick();
      check("cfg_err_clear", WIN_W'(cfg_err), WIN_W'(0));
      pulse_start(MAX_W + 1, 4, 0);
      check("cfg_err_wmax", WIN_W'(cfg_err), WIN_W'(1));
      check("cfg_busy_wmax", WIN_W'(busy), WIN_W'(0));
      check("cfg_ready_wmax", WIN_W'(in_ready), WIN_W'(0));
      tick();
      check("cfg_err_pulses", WIN_W'(cfg_cnt - c0), WIN_W'(2));

      // start during RUN is ignored
      run_frame(5, 4, 0, 0, 1, 1);

      // reset mid-frame
      chk_en = 0;
      pulse_start(16, 16, 0);
      for (int i = 0; i < 20; i++) send_pixel(i);
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      check("abort_out_valid", WIN_W'(out_valid), WIN_W'(0));
      check("abort_in_ready", WIN_W'(in_ready), WIN_W'(0));
      check("abort_busy", WIN_W'(busy), WIN_W'(0));
      check("abort_out_win", out_win, WIN_W'(0));
      check("abort_out_row_col", WIN_W'({out_row, out_col}), WIN_W'(0));
      tick();
      tick();
      reset = 1'b0;
      check("abort_no_done", WIN_W'(done_cnt - d0), WIN_W'(0));
      run_frame(4, 3, 0, 0, 0, 0);
      check("post_abort_0_0", cap_win[0], pack9(0, 0, 0, 0, 0, 1, 0, 4, 5));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
